// File: rtl/memory_dp_clr.sv
// Dual-port RAM: one write port and one registered read port with per-byte enables.
// A clear engine fills every location with CLEAR_VALUE after reset or on request.
//
// state    | meaning
// ST_CLEAR | sweeping ptr over every location, ports ignored, busy=1
// ST_READY | normal read/write service
module memory_dp_clr #(
  parameter int ADDR_LINES = 10,
  parameter int LOC_SIZE   = 32,
  parameter int RDW_MODE   = 1,
  parameter logic [LOC_SIZE-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_LINES-1:0]   wr_addr,
  input  logic [LOC_SIZE-1:0]     wr_data,
  input  logic [LOC_SIZE/8-1:0]   wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_LINES-1:0]   rd_addr,
  output logic [LOC_SIZE-1:0]     rd_data,
  output logic                    rd_valid
);

  localparam int DEPTH = 2 ** ADDR_LINES;
  localparam int NB    = LOC_SIZE / 8;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_LINES-1:0]   ptr_q, ptr_d;
  logic                    clr_we;
  logic                    port_we;
  logic                    port_re;
  logic [LOC_SIZE-1:0]     mem [DEPTH];
  logic [LOC_SIZE-1:0]     rd_old;
  logic [LOC_SIZE-1:0]     rd_merged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // A clr request always wins over port traffic and restarts the sweep at 0.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    port_we = 1'b0;
    port_re = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (clr) begin
          ptr_d = '0;
        end else begin
          clr_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (ptr_q == {ADDR_LINES{1'b1}}) state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else begin
          port_we = wr_en;
          port_re = rd_en;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr_q] <= CLEAR_VALUE;
    end else if (port_we) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // In new-data mode the enabled write bytes bypass the array on an address match.
  always_comb begin
    rd_old    = mem[rd_addr];
    rd_merged = rd_old;
    if (RDW_MODE != 0 && port_we && wr_addr == rd_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_merged[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= port_re;
      if (port_re) rd_data <= rd_merged;
    end
  end

endmodule

// File: tb/tb_memory_dp_clr.sv
// Bench for memory_dp_clr: two instances (new-data and old-data read-during-write)
// share stimulus and are checked each cycle against an array-based reference model.
module tb_memory_dp_clr;
  localparam int AL    = 10;
  localparam int LS    = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 1024;
  localparam logic [31:0] CLR_VAL = 32'h0;

  logic clk = 1'b0;
  logic rst_n, clr, wr_en, rd_en;
  logic [AL-1:0] wr_addr, rd_addr;
  logic [LS-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic busy1, busy0, val1, val0;
  logic [LS-1:0] rd1, rd0;

  always #5 clk = ~clk;

  memory_dp_clr #(.ADDR_LINES(AL), .LOC_SIZE(LS), .RDW_MODE(1), .CLEAR_VALUE(CLR_VAL)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd1), .rd_valid(val1));

  memory_dp_clr #(.ADDR_LINES(AL), .LOC_SIZE(LS), .RDW_MODE(0), .CLEAR_VALUE(CLR_VAL)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd0), .rd_valid(val0));

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_left;
  bit          m_valid;
  logic [31:0] m_rd1, m_rd0;

  typedef struct {
    bit          we;
    logic [9:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          re;
    logic [9:0]  ra;
    bit          ev;
    logic [31:0] e1;
    logic [31:0] e0;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b1;
    m_left  = DEPTH;
    m_valid = 1'b0;
    m_rd1   = '0;
    m_rd0   = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = CLR_VAL;
  endtask

  // Clearing the whole model array at once is equivalent: no read is served while busy.
  task automatic model_edge();
    logic [31:0] old_w, upd;
    if (m_busy) begin
      m_valid = 1'b0;
      if (clr) m_left = DEPTH;
      else begin
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end
    end else if (clr) begin
      m_valid = 1'b0;
      m_busy  = 1'b1;
      m_left  = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = CLR_VAL;
    end else begin
      upd = m_mem[wr_addr];
      for (int b = 0; b < NB; b++) if (wr_be[b]) upd[8*b +: 8] = wr_data[8*b +: 8];
      if (rd_en) begin
        old_w = m_mem[rd_addr];
        m_rd0 = old_w;
        m_rd1 = (wr_en && wr_addr == rd_addr) ? upd : old_w;
      end
      m_valid = rd_en;
      if (wr_en) m_mem[wr_addr] = upd;
    end
  endtask

  task automatic check_outputs();
    chk("busy1", {31'b0, busy1}, {31'b0, m_busy});
    chk("busy0", {31'b0, busy0}, {31'b0, m_busy});
    chk("valid1", {31'b0, val1}, {31'b0, m_valid});
    chk("valid0", {31'b0, val0}, {31'b0, m_valid});
    chk("rd_data1", rd1, m_rd1);
    chk("rd_data0", rd0, m_rd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
  endtask

  task automatic wait_idle(input string name, input int want);
    int n = 0;
    while (busy1 && n < 3000) begin
      step();
      n++;
    end
    chk(name, n, want);
  endtask

  task automatic do_read(input logic [9:0] a, input logic [31:0] want, input string name);
    idle();
    rd_en = 1'b1; rd_addr = a;
    step();
    chk(name, rd1, want);
    chk({name, "_valid"}, {31'b0, val1}, 32'd1);
    rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{1, 10'd5, 32'hDEADBEEF, 4'hF, 0, 10'd0,   0, 32'h0,        32'h0};
    vt[1]  = '{0, 10'd0, 32'h0,        4'h0, 1, 10'd5,   1, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[2]  = '{1, 10'd5, 32'h11223344, 4'h5, 0, 10'd0,   0, 32'h0,        32'h0};
    vt[3]  = '{0, 10'd0, 32'h0,        4'h0, 1, 10'd5,   1, 32'hDE22BE44, 32'hDE22BE44};
    vt[4]  = '{1, 10'd7, 32'hCAFEF00D, 4'hF, 1, 10'd7,   1, 32'hCAFEF00D, 32'h00000000};
    vt[5]  = '{0, 10'd0, 32'h0,        4'h0, 1, 10'd7,   1, 32'hCAFEF00D, 32'hCAFEF00D};
    vt[6]  = '{1, 10'd8, 32'h12345678, 4'h8, 1, 10'd5,   1, 32'hDE22BE44, 32'hDE22BE44};
    vt[7]  = '{0, 10'd0, 32'h0,        4'h0, 1, 10'd8,   1, 32'h12000000, 32'h12000000};
    vt[8]  = '{1, 10'd5, 32'hFFFFFFFF, 4'h0, 1, 10'd5,   1, 32'hDE22BE44, 32'hDE22BE44};
    vt[9]  = '{0, 10'd0, 32'h0,        4'h0, 1, 10'd5,   1, 32'hDE22BE44, 32'hDE22BE44};
    vt[10] = '{0, 10'd0, 32'h0,        4'h0, 1, 10'h3FF, 1, 32'h00000000, 32'h00000000};
    vt[11] = '{0, 10'd0, 32'h0,        4'h0, 0, 10'd0,   0, 32'h0,        32'h0};

    // Reset release with rd_en held high throughout the initial clear.
    idle();
    rst_n = 1'b0;
    rd_en = 1'b1;
    model_reset();
    #22 rst_n = 1'b1;
    chk("busy_after_release", {31'b0, busy1}, 32'd1);
    wait_idle("init_busy_edges", DEPTH);
    do_read(10'h3FF, 32'h0, "rd_3ff_after_init");

    for (int i = 0; i < 12; i++) begin
      idle();
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd; wr_be = vt[i].be;
      rd_en = vt[i].re; rd_addr = vt[i].ra;
      step();
      chk($sformatf("vec%0d_valid", i), {31'b0, val1}, {31'b0, vt[i].ev});
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_rd_new", i), rd1, vt[i].e1);
        chk($sformatf("vec%0d_rd_old", i), rd0, vt[i].e0);
      end
    end

    // clr alongside a write: the write is dropped, writes during busy are ignored.
    idle();
    wr_en = 1'b1; wr_addr = 10'd9; wr_data = 32'h99999999; wr_be = 4'hF;
    step();
    clr = 1'b1; wr_data = 32'h55555555; rd_en = 1'b1; rd_addr = 10'd9;
    step();
    chk("busy_after_clr", {31'b0, busy1}, 32'd1);
    clr = 1'b0;
    wr_en = 1'b1; rd_en = 1'b1; wr_be = 4'hF;
    wr_addr = 10'd5; wr_data = 32'hA5A5A5A5;
    wait_idle("clr_busy_edges", DEPTH);
    do_read(10'd5, 32'h0, "rd5_after_clr");
    do_read(10'd9, 32'h0, "rd9_after_clr");

    // clr during an active sweep restarts it from location 0.
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 200; i++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    wait_idle("restart_busy_edges", DEPTH);

    // Reset asserted mid-sweep at ptr=300.
    idle();
    wr_en = 1'b1; wr_addr = 10'd3; wr_data = 32'hA5A5A5A5; wr_be = 4'hF;
    step();
    idle();
    rd_en = 1'b1; rd_addr = 10'd3;
    step();
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 300; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_data1", rd1, 32'h0);
    chk("rst_rd_data0", rd0, 32'h0);
    chk("rst_rd_valid", {31'b0, val1}, 32'd0);
    chk("rst_busy", {31'b0, busy1}, 32'd1);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_idle("rst_busy_edges", DEPTH);
    do_read(10'd3, 32'h0, "rd3_after_rst");

    // Randomised traffic on a small address window so collisions are frequent.
    for (int i = 0; i < 800; i++) begin
      clr     = (i < 500) && ($urandom_range(0, 299) == 0);
      wr_en   = $urandom_range(0, 1) == 1;
      rd_en   = $urandom_range(0, 1) == 1;
      wr_addr = 10'($urandom_range(0, 15));
      rd_addr = 10'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
